// File: rtl/mem_nrnw_if.sv
// Bus bundle for mem_nrnw: per-port read/write handshakes, packed port-major.
interface mem_nrnw_if #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NR    = 2,
    parameter int unsigned NW    = 2
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MB = W / 8;

    logic [NR-1:0]    ren;
    logic [NR*AW-1:0] raddr;
    logic [NR*W-1:0]  rdata;
    logic [NR-1:0]    rvalid;
    logic [NW-1:0]    wen;
    logic [NW*AW-1:0] waddr;
    logic [NW*W-1:0]  wdata;
    logic [NW*MB-1:0] wmask;
    logic             init_busy;

    modport master (
        output ren, raddr, wen, waddr, wdata, wmask,
        input  rdata, rvalid, init_busy
    );

    modport slave (
        input  ren, raddr, wen, waddr, wdata, wmask,
        output rdata, rvalid, init_busy
    );
endinterface

// File: rtl/mem_nrnw.sv
// NR-read / NW-write synchronous-read memory with byte masks and per-byte write priority.
// Optional post-reset clear sweep: define MEM_NRNW_RESET_CLEAR_EN.
module mem_nrnw #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NR    = 2,
    parameter int unsigned NW    = 2
) (
    input  logic      clock,
    input  logic      reset,
    mem_nrnw_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MB = W / 8;

    logic [W-1:0]          mem_q [DEPTH];
    logic [W-1:0]          mem_d [DEPTH];
    logic [NR-1:0][AW-1:0] raddr_q, raddr_d;
    logic [NR-1:0]         rvalid_q, rvalid_d;
    logic                  init_busy;

    // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

`ifdef MEM_NRNW_RESET_CLEAR_EN
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
                state_d   = IDLE;
                clr_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign init_busy = (state_q == CLEAR);
`else
    assign init_busy = 1'b0;
`endif

    // Ports applied in ascending order so the highest index owns each contested byte.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NW; j++) begin
            if (bus.wen[j] && !init_busy && in_range(bus.waddr[j*AW +: AW])) begin
                for (int b = 0; b < MB; b++) begin
                    if (bus.wmask[j*MB + b]) begin
                        mem_d[bus.waddr[j*AW +: AW]][b*8 +: 8] = bus.wdata[j*W + b*8 +: 8];
                    end
                end
            end
        end
`ifdef MEM_NRNW_RESET_CLEAR_EN
        if (state_q == CLEAR) begin
            mem_d[clr_cnt_q] = '0;
        end
`endif
    end

    // Array is deliberately outside reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        raddr_d  = raddr_q;
        rvalid_d = '0;
        for (int i = 0; i < NR; i++) begin
            if (bus.ren[i] && !init_busy) begin
                raddr_d[i]  = bus.raddr[i*AW +: AW];
                rvalid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            raddr_q  <= '0;
            rvalid_q <= '0;
        end else begin
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Read data follows the held address, so it tracks later writes to that entry.
    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < NR; i++) begin
            if (!init_busy && in_range(raddr_q[i])) begin
                bus.rdata[i*W +: W] = mem_q[raddr_q[i]];
            end
        end
    end

    assign bus.rvalid    = rvalid_q;
    assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_mem_nrnw.sv
// Self-checking bench for mem_nrnw (W=64, DEPTH=20, NR=4, NW=3) against a behavioural model.
module tb_mem_nrnw;
    localparam int W     = 64;
    localparam int DEPTH = 20;
    localparam int NR    = 4;
    localparam int NW    = 3;
    localparam int AW    = 5;
    localparam int MB    = 8;
`ifdef MEM_NRNW_RESET_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [W-1:0] model_mem [DEPTH];
    int           model_haddr [NR];
    logic         model_rvalid [NR];
    int           model_busy_cnt = 0;

    mem_nrnw_if #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus ();

    mem_nrnw #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic idle();
        bus.wen   = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.wmask = '0;
        bus.ren   = '0;
        bus.raddr = '0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [W-1:0] d, input logic [MB-1:0] m);
        bus.wen[j]             = 1'b1;
        bus.waddr[j*AW +: AW]  = AW'(a);
        bus.wdata[j*W +: W]    = d;
        bus.wmask[j*MB +: MB]  = m;
    endtask

    task automatic set_rd(input int i, input int a);
        bus.ren[i]            = 1'b1;
        bus.raddr[i*AW +: AW] = AW'(a);
    endtask

    function automatic logic [W-1:0] exp_rdata(input int i);
        if (model_busy_cnt != 0 || model_haddr[i] >= DEPTH) return '0;
        return model_mem[model_haddr[i]];
    endfunction

    // Apply the memory's rules to the inputs present now, then advance one edge.
    task automatic tick();
        bit claimed [DEPTH][MB];
        bit busy;
        int a;
        busy = (model_busy_cnt != 0);
        if (!busy) begin
            for (int j = NW - 1; j >= 0; j--) begin
                if (bus.wen[j]) begin
                    a = int'(bus.waddr[j*AW +: AW]);
                    if (a < DEPTH) begin
                        for (int b = 0; b < MB; b++) begin
                            if (bus.wmask[j*MB + b] && !claimed[a][b]) begin
                                model_mem[a][b*8 +: 8] = bus.wdata[j*W + b*8 +: 8];
                                claimed[a][b] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (reset) begin
                model_haddr[i]  = 0;
                model_rvalid[i] = 1'b0;
            end else if (bus.ren[i] && !busy) begin
                model_haddr[i]  = int'(bus.raddr[i*AW +: AW]);
                model_rvalid[i] = 1'b1;
            end else begin
                model_rvalid[i] = 1'b0;
            end
        end
`ifdef MEM_NRNW_RESET_CLEAR_EN
        if (reset) begin
            model_busy_cnt = DEPTH;
        end else if (model_busy_cnt > 0) begin
            model_busy_cnt--;
            if (model_busy_cnt == 0) begin
                for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
            end
        end
`endif
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int n;
        idle();
        reset = 1'b1;
        bus.ren = '1;
        tick();
        tick();
        n_cmp++;
        if (bus.rvalid !== '0) begin
            n_err++;
            $display("FAIL reset_rvalid: got %b required %b", bus.rvalid, 4'b0000);
        end
        n_cmp++;
        if (bus.init_busy !== EXP_BUSY) begin
            n_err++;
            $display("FAIL reset_busy: got %b required %b", bus.init_busy, EXP_BUSY);
        end
        reset = 1'b0;
        idle();
`ifdef MEM_NRNW_RESET_CLEAR_EN
        n = 0;
        while (bus.init_busy === 1'b1 && n < DEPTH + 8) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != DEPTH) begin
            n_err++;
            $display("FAIL reset_busy_len: got %0d cycles required %0d", n, DEPTH);
        end
`else
        n = 0;
        tick();
`endif
    endtask

`ifdef MEM_NRNW_RESET_CLEAR_EN
    task automatic test_clear();
        int n;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_wr(0, 0, '1, '1);
        tick();
        idle();
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.rdata !== '0) begin
            n_err++;
            $display("FAIL clear_busy_rdata: got %h required 0", bus.rdata);
        end
        n = 0;
        while (bus.init_busy === 1'b1 && n < DEPTH + 8) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != DEPTH) begin
            n_err++;
            $display("FAIL clear_restart_len: got %0d cycles required %0d", n, DEPTH);
        end
        for (int a = 0; a < DEPTH; a += NR) begin
            idle();
            for (int i = 0; i < NR; i++) set_rd(i, a + i);
            tick();
            for (int i = 0; i < NR; i++) begin
                n_cmp++;
                if (bus.rdata[i*W +: W] !== 64'h0) begin
                    n_err++;
                    $display("FAIL clear_zero addr %0d: got %h required 0", a + i, bus.rdata[i*W +: W]);
                end
            end
        end
        idle();
    endtask
`endif

    task automatic test_fill();
        for (int a = 0; a < DEPTH; a += NW) begin
            idle();
            for (int j = 0; j < NW; j++) begin
                if (a + j < DEPTH) set_wr(j, a + j, {$urandom, $urandom}, '1);
            end
            tick();
        end
        idle();
        tick();
        for (int i = 0; i < NR; i++) begin
            n_cmp++;
            if (bus.rdata[i*W +: W] !== model_mem[0]) begin
                n_err++;
                $display("FAIL fill_held_addr0 port %0d: got %h required %h", i, bus.rdata[i*W +: W], model_mem[0]);
            end
        end
    endtask

    task automatic test_basic();
        idle();
        set_wr(0, 5, 64'h1122334455667788, 8'hFF);
        tick();
        idle();
        set_rd(0, 5);
        tick();
        n_cmp++;
        if (bus.rdata[0 +: W] !== 64'h1122334455667788) begin
            n_err++;
            $display("FAIL basic_rdata: got %h required %h", bus.rdata[0 +: W], 64'h1122334455667788);
        end
        n_cmp++;
        if (bus.rvalid !== 4'b0001) begin
            n_err++;
            $display("FAIL basic_rvalid: got %b required %b", bus.rvalid, 4'b0001);
        end
        idle();
        tick();
        n_cmp++;
        if (bus.rvalid[0] !== 1'b0 || bus.rdata[0 +: W] !== 64'h1122334455667788) begin
            n_err++;
            $display("FAIL basic_pulse: got rvalid %b data %h required 0 / %h",
                     bus.rvalid[0], bus.rdata[0 +: W], 64'h1122334455667788);
        end
    endtask

    task automatic test_collision();
        idle();
        set_wr(0, 3, {8{8'hAA}}, 8'hFF);
        set_wr(1, 3, {8{8'h55}}, 8'h0F);
        tick();
        idle();
        set_wr(0, 4, {8{8'hFF}}, 8'hFF);
        set_wr(1, 4, 64'h0,      8'hF0);
        set_wr(2, 4, 64'h12,     8'h01);
        set_rd(1, 3);
        tick();
        n_cmp++;
        if (bus.rdata[1*W +: W] !== 64'hAAAAAAAA55555555) begin
            n_err++;
            $display("FAIL collision_2port: got %h required %h", bus.rdata[1*W +: W], 64'hAAAAAAAA55555555);
        end
        idle();
        set_wr(2, 6, {8{8'h99}}, 8'h00);
        set_rd(2, 4);
        tick();
        n_cmp++;
        if (bus.rdata[2*W +: W] !== 64'h00000000FFFFFF12) begin
            n_err++;
            $display("FAIL collision_3port: got %h required %h", bus.rdata[2*W +: W], 64'h00000000FFFFFF12);
        end
        idle();
        set_rd(3, 6);
        tick();
        n_cmp++;
        if (bus.rdata[3*W +: W] !== model_mem[6]) begin
            n_err++;
            $display("FAIL zero_mask_noop: got %h required %h", bus.rdata[3*W +: W], model_mem[6]);
        end
    endtask

    task automatic test_hold_track();
        idle();
        set_rd(0, 7);
        tick();
        idle();
        set_wr(1, 7, 64'hDEAD, 8'hFF);
        tick();
        n_cmp++;
        if (bus.rdata[0 +: W] !== 64'hDEAD) begin
            n_err++;
            $display("FAIL hold_track_rdata: got %h required %h", bus.rdata[0 +: W], 64'hDEAD);
        end
        n_cmp++;
        if (bus.rvalid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL hold_track_rvalid: got %b required 0", bus.rvalid[0]);
        end
        idle();
    endtask

    task automatic test_out_of_range();
        idle();
        for (int j = 0; j < NW; j++) set_wr(j, 25 - j, 64'hFF, 8'hFF);
        tick();
        idle();
        set_rd(2, 25);
        tick();
        n_cmp++;
        if (bus.rdata[2*W +: W] !== 64'h0 || bus.rvalid[2] !== 1'b1) begin
            n_err++;
            $display("FAIL oor_read: got data %h rvalid %b required 0 / 1", bus.rdata[2*W +: W], bus.rvalid[2]);
        end
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            set_rd(3, a);
            tick();
            n_cmp++;
            if (bus.rdata[3*W +: W] !== model_mem[a]) begin
                n_err++;
                $display("FAIL oor_unchanged addr %0d: got %h required %h", a, bus.rdata[3*W +: W], model_mem[a]);
            end
        end
        idle();
    endtask

    task automatic test_multi_read();
        idle();
        set_wr(2, 9, 64'hCAFEF00D, 8'hFF);
        tick();
        idle();
        for (int i = 0; i < NR; i++) set_rd(i, 9);
        tick();
        for (int i = 0; i < NR; i++) begin
            n_cmp++;
            if (bus.rdata[i*W +: W] !== 64'hCAFEF00D || bus.rvalid[i] !== 1'b1) begin
                n_err++;
                $display("FAIL multi_read port %0d: got %h rvalid %b required %h / 1",
                         i, bus.rdata[i*W +: W], bus.rvalid[i], 64'hCAFEF00D);
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int j = 0; j < NW; j++) begin
                bus.wen[j]            = ($urandom_range(0, 1) == 1);
                bus.waddr[j*AW +: AW] = AW'($urandom_range(0, 23));
                bus.wdata[j*W +: W]   = {$urandom, $urandom};
                bus.wmask[j*MB +: MB] = ($urandom_range(0, 3) == 0) ? 8'hFF : MB'($urandom);
            end
            for (int i = 0; i < NR; i++) begin
                bus.ren[i]            = ($urandom_range(0, 1) == 1);
                bus.raddr[i*AW +: AW] = AW'($urandom_range(0, 23));
            end
            tick();
            for (int i = 0; i < NR; i++) begin
                n_cmp++;
                if (bus.rdata[i*W +: W] !== exp_rdata(i) || bus.rvalid[i] !== model_rvalid[i]) begin
                    n_err++;
                    $display("FAIL random cyc %0d port %0d: got %h/%b required %h/%b",
                             c, i, bus.rdata[i*W +: W], bus.rvalid[i], exp_rdata(i), model_rvalid[i]);
                end
            end
            n_cmp++;
            if (bus.init_busy !== (model_busy_cnt != 0)) begin
                n_err++;
                $display("FAIL random_busy cyc %0d: got %b required %b", c, bus.init_busy, model_busy_cnt != 0);
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
`ifdef MEM_NRNW_RESET_CLEAR_EN
        test_clear();
`endif
        test_fill();
        test_basic();
        test_collision();
        test_hold_track();
        test_out_of_range();
        test_multi_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
